pkt_prio_slots: RTL

- Parametrised successor to the single-input packet comparator: a shared slot pool that accepts packets from NUM_CH input channels and always presents the best-priority stored packet at one dequeue port.
- Equal priorities leave in arrival order.
- A mode parameter selects lowest-value-first or highest-value-first.
- Adds a synchronous flush and occupancy reporting.
- Sits between the per-port packet header parsers and the egress scheduler.

---
 rtl/pkt_h.sv | 24 ++
 rtl/pkt_rr_arb.sv | 58 +++++
 rtl/pkt_prio_slots.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pkt_h.sv
// Shared packet-path definitions: default widths, the slot entry layout and
// a small width helper used by the priority slot pool and its ingress arbiter.
package pkt_h;

    localparam int PRIO_W_DEF    = 6;
    localparam int DWIDTH_DEF    = 32;
    localparam int SLOT_SIZE_DEF = 8;
    localparam int CW_DEF        = 1;
    localparam int AGE_W_DEF     = $clog2(SLOT_SIZE_DEF);

    typedef struct packed {
        logic                  valid;
        logic [PRIO_W_DEF-1:0] prior;
        logic [DWIDTH_DEF-1:0] data;
        logic [CW_DEF-1:0]     chan;
        logic [AGE_W_DEF-1:0]  age;
    } slot_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pkt_rr_arb.sv
// N-wide round-robin arbiter: search starts at the pointer, and the pointer
// moves past the winner only when the grant is actually taken (en high).
module pkt_rr_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                grant_idx = IW'(idx);
            end
        end
        if (!en) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : IW'(int'(grant_idx) + 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pkt_prio_slots.sv
// Multi-channel priority slot pool: stores up to SLOT_SIZE packets and always
// presents the best-priority one (oldest first among equal priorities).
module pkt_prio_slots
    import pkt_h::*;
#(
    parameter int DWIDTH     = 32,
    parameter int SLOT_SIZE  = 8,
    parameter int PRIO_W     = PRIO_W_DEF,
    parameter int NUM_CH     = 2,
    parameter int HIGH_FIRST = 0,
    parameter int CW         = clog2_min1(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              in_en,
    output logic [NUM_CH-1:0]              in_valid,
    input  logic [NUM_CH*PRIO_W-1:0]       in_prior,
    input  logic [NUM_CH*DWIDTH-1:0]       in_data,
    input  logic                           flush,
    input  logic                           out_deque_en,
    output logic                           out_valid,
    output logic [DWIDTH-1:0]              out_data,
    output logic [PRIO_W-1:0]              out_prior,
    output logic [CW-1:0]                  out_chan,
    output logic [$clog2(SLOT_SIZE+1)-1:0] count
);

    localparam int AW   = $clog2(SLOT_SIZE);
    localparam int CNTW = $clog2(SLOT_SIZE + 1);

    typedef struct packed {
        logic              valid;
        logic [PRIO_W-1:0] prior;
        logic [DWIDTH-1:0] data;
        logic [CW-1:0]     chan;
        logic [AW-1:0]     age;
    } slot_entry_t;

    slot_entry_t   slot_q [SLOT_SIZE];
    slot_entry_t   slot_d [SLOT_SIZE];
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    logic          best_found;
    logic [AW-1:0] best_idx;
    logic [AW-1:0] free_idx;
    logic          arb_en;
    logic          ins;
    logic          deq;
    logic [CW-1:0] win_idx;
    int            rank;

    function automatic logic beats(input slot_entry_t a, input slot_entry_t b);
        if (a.prior == b.prior) begin
            return a.age > b.age;
        end
        return (HIGH_FIRST != 0) ? (a.prior > b.prior) : (a.prior < b.prior);
    endfunction

    assign arb_en = rst && !flush && (count_q < CNTW'(SLOT_SIZE));

    pkt_rr_arb #(
        .N  (NUM_CH),
        .IW (CW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_en),
        .en        (arb_en),
        .grant     (in_valid),
        .grant_idx (win_idx),
        .grant_any (ins)
    );

    always_comb begin
        best_found = 1'b0;
        best_idx   = '0;
        free_idx   = '0;
        for (int i = 0; i < SLOT_SIZE; i++) begin
            if (slot_q[i].valid && (!best_found || beats(slot_q[i], slot_q[best_idx]))) begin
                best_found = 1'b1;
                best_idx   = AW'(i);
            end
        end
        for (int i = SLOT_SIZE - 1; i >= 0; i--) begin
            if (!slot_q[i].valid) begin
                free_idx = AW'(i);
            end
        end
    end

    assign deq = out_deque_en && best_found && !flush;

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        rank    = 0;
        if (flush) begin
            for (int i = 0; i < SLOT_SIZE; i++) begin
                slot_d[i].valid = 1'b0;
            end
            count_d = '0;
        end else begin
            if (deq) begin
                slot_d[best_idx].valid = 1'b0;
            end
            if (ins) begin
                // Re-rank survivors so ages stay dense (0..n-1) after out-of-order
                // pops; relative order is unchanged and the width never overflows.
                for (int i = 0; i < SLOT_SIZE; i++) begin
                    if (slot_d[i].valid) begin
                        rank = 1;
                        for (int j = 0; j < SLOT_SIZE; j++) begin
                            if (j != i && slot_d[j].valid && slot_q[j].age < slot_q[i].age) begin
                                rank = rank + 1;
                            end
                        end
                        slot_d[i].age = AW'(rank);
                    end
                end
                slot_d[free_idx].valid = 1'b1;
                slot_d[free_idx].prior = in_prior[win_idx*PRIO_W +: PRIO_W];
                slot_d[free_idx].data  = in_data[win_idx*DWIDTH +: DWIDTH];
                slot_d[free_idx].chan  = win_idx;
                slot_d[free_idx].age   = '0;
            end
            if (ins && !deq) begin
                count_d = count_q + CNTW'(1);
            end else if (deq && !ins) begin
                count_d = count_q - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SLOT_SIZE; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    assign out_valid = best_found;
    assign out_data  = best_found ? slot_q[best_idx].data  : '0;
    assign out_prior = best_found ? slot_q[best_idx].prior : '0;
    assign out_chan  = best_found ? slot_q[best_idx].chan  : '0;
    assign count     = count_q;

endmodule
